// File: rtl/mem_stage_if.sv
// EX/MEM inputs and MEM/WB outputs of the memory stage, bundled as one port.
// The master is whoever drives the EX/MEM side; the slave is mem_stage itself.
interface mem_stage_if;
   logic [31:0] ALUResult;
   logic [31:0] ReadDataRF1;
   logic [4:0]  WriteRegister;
   logic [4:0]  Rt;
   logic        RegWrite;
   logic        MemRead;
   logic        MemWrite;
   logic        MemToReg;

   logic        RegWriteWB;
   logic        MemToRegWB;
   logic [4:0]  WriteRegisterWB;
   logic [31:0] ALUResultWB;
   logic [31:0] ReadDataWB;
   logic [31:0] WriteDataWB;

   modport master (
      output ALUResult, ReadDataRF1, WriteRegister, Rt,
             RegWrite, MemRead, MemWrite, MemToReg,
      input  RegWriteWB, MemToRegWB, WriteRegisterWB,
             ALUResultWB, ReadDataWB, WriteDataWB
   );

   modport slave (
      input  ALUResult, ReadDataRF1, WriteRegister, Rt,
             RegWrite, MemRead, MemWrite, MemToReg,
      output RegWriteWB, MemToRegWB, WriteRegisterWB,
             ALUResultWB, ReadDataWB, WriteDataWB
   );
endinterface

// File: rtl/mem_stage.sv
// MIPS memory stage: word-addressed data memory, store-data forwarding from
// the MEM/WB register, and the MEM/WB pipeline register itself.
module mem_stage #(
   parameter int ADDR_WIDTH = 10
) (
   input logic       clk,
   input logic       rst,
   mem_stage_if.slave bus
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   logic [31:0]           mem [DEPTH];
   logic [ADDR_WIDTH-1:0] word_index;
   logic [31:0]           read_word;
   logic [31:0]           store_data;
   logic [31:0]           write_data;
   logic                  forward_sel;

   logic                  reg_write_reg;
   logic                  mem_to_reg_reg;
   logic [4:0]            write_register_reg;
   logic [31:0]           alu_result_reg;
   logic [31:0]           read_data_reg;

   // Byte offset dropped and upper bits ignored, so addresses wrap.
   assign word_index = bus.ALUResult[ADDR_WIDTH+1:2];
   assign read_word  = mem[word_index];

   assign write_data = mem_to_reg_reg ? read_data_reg : alu_result_reg;

   // Lets a sw consume the value of the instruction directly ahead of it.
   assign forward_sel = reg_write_reg && (write_register_reg != 5'd0) &&
                        (write_register_reg == bus.Rt);
   assign store_data  = forward_sel ? write_data : bus.ReadDataRF1;

   // Memory contents survive reset; only writes during reset are blocked.
   always_ff @(posedge clk) begin
      if (!rst && bus.MemWrite) begin
         mem[word_index] <= store_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         reg_write_reg      <= 1'b0;
         mem_to_reg_reg     <= 1'b0;
         write_register_reg <= 5'd0;
         alu_result_reg     <= 32'd0;
         read_data_reg      <= 32'd0;
      end else begin
         reg_write_reg      <= bus.RegWrite;
         mem_to_reg_reg     <= bus.MemToReg;
         write_register_reg <= bus.WriteRegister;
         alu_result_reg     <= bus.ALUResult;
         read_data_reg      <= bus.MemRead ? read_word : 32'd0;
      end
   end

   assign bus.RegWriteWB      = reg_write_reg;
   assign bus.MemToRegWB      = mem_to_reg_reg;
   assign bus.WriteRegisterWB = write_register_reg;
   assign bus.ALUResultWB     = alu_result_reg;
   assign bus.ReadDataWB      = read_data_reg;
   assign bus.WriteDataWB     = write_data;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: each issued instruction pushes its expected
// MEM/WB contents, popped and compared one clock later.
module tb_mem_stage;

   typedef struct {
      logic        rw;
      logic        m2r;
      logic [4:0]  wr;
      logic [31:0] alu;
      logic [31:0] rd;
      logic [31:0] wd;
   } exp_t;

   logic clk;
   logic rst;
   mem_stage_if bus ();

   mem_stage #(.ADDR_WIDTH(10)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   exp_t        sb[$];
   logic [31:0] mdl[int];
   logic        m_rw, m_m2r;
   logic [4:0]  m_wr;
   logic [31:0] m_alu, m_rd;
   int          n_chk = 0;
   int          n_fail = 0;

   task automatic model_reset();
      m_rw = 0; m_m2r = 0; m_wr = 0; m_alu = 0; m_rd = 0;
   endtask

   task automatic bubble();
      bus.RegWrite = 0; bus.MemRead = 0; bus.MemWrite = 0; bus.MemToReg = 0;
      bus.WriteRegister = 0; bus.Rt = 0; bus.ALUResult = 0; bus.ReadDataRF1 = 0;
   endtask

   // Drive one EX/MEM instruction and push what MEM/WB must show after the edge.
   task automatic send(input logic rw, input logic mr, input logic mw, input logic m2r,
                       input logic [4:0] wr, input logic [4:0] rt,
                       input logic [31:0] alu, input logic [31:0] rf1);
      exp_t        e;
      int          idx;
      logic [31:0] sd, rd;
      bus.RegWrite = rw; bus.MemRead = mr; bus.MemWrite = mw; bus.MemToReg = m2r;
      bus.WriteRegister = wr; bus.Rt = rt; bus.ALUResult = alu; bus.ReadDataRF1 = rf1;
      idx = int'(alu[11:2]);
      sd  = (m_rw && m_wr != 0 && m_wr == rt) ? (m_m2r ? m_rd : m_alu) : rf1;
      rd  = 32'd0;
      if (mr) rd = mdl.exists(idx) ? mdl[idx] : 32'd0;
      if (mw) mdl[idx] = sd;
      m_rw = rw; m_m2r = m2r; m_wr = wr; m_alu = alu; m_rd = rd;
      e.rw = rw; e.m2r = m2r; e.wr = wr; e.alu = alu; e.rd = rd;
      e.wd = m2r ? rd : alu;
      sb.push_back(e);
      $display("txn rw=%0b mr=%0b mw=%0b m2r=%0b wr=%0d rt=%0d alu=%h rf1=%h sd=%h",
               rw, mr, mw, m2r, wr, rt, alu, rf1, sd);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      exp_t e;
      // Power-up reset is already asserted.
      tick();
      n_chk++; if (bus.RegWriteWB !== 1'b0) begin n_fail++; $display("FAIL por_rw: got %b want 0", bus.RegWriteWB); end
      n_chk++; if (bus.WriteDataWB !== 32'd0) begin n_fail++; $display("FAIL por_wd: got %h want 0", bus.WriteDataWB); end
      @(negedge clk);
      rst = 0;
      model_reset();
      send(0, 0, 1, 0, 5'd0, 5'd0, 32'h100, 32'h5A5A5A5A); tick(); e = sb.pop_front();
      send(1, 1, 0, 1, 5'd3, 5'd0, 32'h100, 32'h0);        tick(); e = sb.pop_front();
      n_chk++; if (bus.ReadDataWB !== e.rd) begin n_fail++; $display("FAIL pre_rst_rd: got %h want %h", bus.ReadDataWB, e.rd); end
      // Mid-cycle reset with a live store on the inputs.
      #3;
      bus.RegWrite = 1; bus.MemRead = 1; bus.MemWrite = 1; bus.MemToReg = 1;
      bus.WriteRegister = 5'd7; bus.Rt = 5'd0; bus.ALUResult = 32'h100; bus.ReadDataRF1 = 32'hFFFFFFFF;
      rst = 1;
      #1;
      n_chk++; if (bus.RegWriteWB !== 1'b0) begin n_fail++; $display("FAIL rst_rw: got %b want 0", bus.RegWriteWB); end
      n_chk++; if (bus.MemToRegWB !== 1'b0) begin n_fail++; $display("FAIL rst_m2r: got %b want 0", bus.MemToRegWB); end
      n_chk++; if (bus.WriteRegisterWB !== 5'd0) begin n_fail++; $display("FAIL rst_wr: got %h want 0", bus.WriteRegisterWB); end
      n_chk++; if (bus.ALUResultWB !== 32'd0) begin n_fail++; $display("FAIL rst_alu: got %h want 0", bus.ALUResultWB); end
      n_chk++; if (bus.ReadDataWB !== 32'd0) begin n_fail++; $display("FAIL rst_rd: got %h want 0", bus.ReadDataWB); end
      n_chk++; if (bus.WriteDataWB !== 32'd0) begin n_fail++; $display("FAIL rst_wd: got %h want 0", bus.WriteDataWB); end
      tick();
      n_chk++; if (bus.ReadDataWB !== 32'd0) begin n_fail++; $display("FAIL rst_hold_rd: got %h want 0", bus.ReadDataWB); end
      n_chk++; if (bus.ALUResultWB !== 32'd0) begin n_fail++; $display("FAIL rst_hold_alu: got %h want 0", bus.ALUResultWB); end
      bubble();
      rst = 0;
      model_reset();
      send(1, 1, 0, 1, 5'd2, 5'd0, 32'h100, 32'h0); tick(); e = sb.pop_front();
      n_chk++; if (bus.ReadDataWB !== 32'h5A5A5A5A) begin n_fail++; $display("FAIL rst_no_write: got %h want %h", bus.ReadDataWB, 32'h5A5A5A5A); end
   endtask

   task automatic test_store_load();
      exp_t e;
      send(0, 0, 1, 0, 5'd0, 5'd0, 32'h40, 32'hDEADBEEF); tick(); e = sb.pop_front();
      n_chk++; if (bus.RegWriteWB !== e.rw) begin n_fail++; $display("FAIL sw_rw: got %b want %b", bus.RegWriteWB, e.rw); end
      send(1, 1, 0, 1, 5'd4, 5'd0, 32'h40, 32'h0); tick(); e = sb.pop_front();
      n_chk++; if (bus.ReadDataWB !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lw_rd: got %h want %h", bus.ReadDataWB, 32'hDEADBEEF); end
      n_chk++; if (bus.WriteDataWB !== e.wd) begin n_fail++; $display("FAIL lw_wd: got %h want %h", bus.WriteDataWB, e.wd); end
      n_chk++; if (bus.MemToRegWB !== 1'b1) begin n_fail++; $display("FAIL lw_m2r: got %b want 1", bus.MemToRegWB); end
      n_chk++; if (bus.WriteRegisterWB !== 5'd4) begin n_fail++; $display("FAIL lw_wr: got %0d want 4", bus.WriteRegisterWB); end
   endtask

   task automatic test_wrap();
      exp_t e;
      send(0, 0, 1, 0, 5'd0, 5'd0, 32'h1000, 32'h11); tick(); e = sb.pop_front();
      send(1, 1, 0, 1, 5'd5, 5'd0, 32'h0002, 32'h0);  tick(); e = sb.pop_front();
      n_chk++; if (bus.ReadDataWB !== 32'h11) begin n_fail++; $display("FAIL wrap_rd: got %h want %h", bus.ReadDataWB, 32'h11); end
      n_chk++; if (bus.ReadDataWB !== e.rd) begin n_fail++; $display("FAIL wrap_model: got %h want %h", bus.ReadDataWB, e.rd); end
   endtask

   task automatic test_forward();
      exp_t e;
      send(0, 0, 1, 0, 5'd0, 5'd0, 32'h20, 32'h1234); tick(); e = sb.pop_front();
      // lw $8 then sw $8: forwarded
      send(1, 1, 0, 1, 5'd8, 5'd0, 32'h20, 32'h0);     tick(); e = sb.pop_front();
      send(0, 0, 1, 0, 5'd0, 5'd8, 32'h80, 32'hFFFF);  tick(); e = sb.pop_front();
      send(1, 1, 0, 1, 5'd10, 5'd0, 32'h80, 32'h0);    tick(); e = sb.pop_front();
      n_chk++; if (bus.ReadDataWB !== 32'h1234) begin n_fail++; $display("FAIL fwd_hit: got %h want %h", bus.ReadDataWB, 32'h1234); end
      // lw $8 then sw $9: not forwarded
      send(1, 1, 0, 1, 5'd8, 5'd0, 32'h20, 32'h0);     tick(); e = sb.pop_front();
      send(0, 0, 1, 0, 5'd0, 5'd9, 32'h80, 32'hFFFF);  tick(); e = sb.pop_front();
      send(1, 1, 0, 1, 5'd10, 5'd0, 32'h80, 32'h0);    tick(); e = sb.pop_front();
      n_chk++; if (bus.ReadDataWB !== 32'hFFFF) begin n_fail++; $display("FAIL fwd_miss: got %h want %h", bus.ReadDataWB, 32'hFFFF); end
      // lw $0 then sw $0: never forwarded
      send(1, 1, 0, 1, 5'd0, 5'd0, 32'h20, 32'h0);     tick(); e = sb.pop_front();
      send(0, 0, 1, 0, 5'd0, 5'd0, 32'h80, 32'hCAFE);  tick(); e = sb.pop_front();
      send(1, 1, 0, 1, 5'd10, 5'd0, 32'h80, 32'h0);    tick(); e = sb.pop_front();
      n_chk++; if (bus.ReadDataWB !== 32'hCAFE) begin n_fail++; $display("FAIL fwd_zero: got %h want %h", bus.ReadDataWB, 32'hCAFE); end
   endtask

   task automatic test_passthrough();
      exp_t e;
      send(1, 0, 0, 0, 5'd3, 5'd0, 32'h55, 32'h0); tick(); e = sb.pop_front();
      n_chk++; if (bus.ALUResultWB !== 32'h55) begin n_fail++; $display("FAIL pt_alu: got %h want %h", bus.ALUResultWB, 32'h55); end
      n_chk++; if (bus.ReadDataWB !== 32'h0) begin n_fail++; $display("FAIL pt_rd: got %h want 0", bus.ReadDataWB); end
      n_chk++; if (bus.WriteDataWB !== 32'h55) begin n_fail++; $display("FAIL pt_wd: got %h want %h", bus.WriteDataWB, 32'h55); end
      n_chk++; if (bus.WriteRegisterWB !== 5'd3) begin n_fail++; $display("FAIL pt_wr: got %0d want 3", bus.WriteRegisterWB); end
      n_chk++; if (bus.RegWriteWB !== e.rw) begin n_fail++; $display("FAIL pt_rw: got %b want %b", bus.RegWriteWB, e.rw); end
   endtask

   task automatic test_read_write();
      exp_t e;
      send(0, 0, 1, 0, 5'd0, 5'd0, 32'h200, 32'hA); tick(); e = sb.pop_front();
      send(1, 1, 1, 1, 5'd7, 5'd0, 32'h200, 32'hB); tick(); e = sb.pop_front();
      n_chk++; if (bus.ReadDataWB !== 32'hA) begin n_fail++; $display("FAIL rw_old: got %h want %h", bus.ReadDataWB, 32'hA); end
      send(1, 1, 0, 1, 5'd6, 5'd0, 32'h200, 32'h0); tick(); e = sb.pop_front();
      n_chk++; if (bus.ReadDataWB !== 32'hB) begin n_fail++; $display("FAIL rw_new: got %h want %h", bus.ReadDataWB, 32'hB); end
   endtask

   task automatic test_back_to_back();
      exp_t        e;
      logic [31:0] addr;
      int          op;
      for (int k = 0; k < 8; k++) begin
         send(0, 0, 1, 0, 5'd0, 5'd0, 32'h300 + 32'(4 * k), $urandom); tick(); e = sb.pop_front();
      end
      for (int i = 0; i < 40; i++) begin
         op   = $urandom_range(0, 3);
         addr = 32'h300 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
         case (op)
            0: send(1, 0, 0, 0, 5'($urandom_range(0, 15)), 5'd0, $urandom, 32'h0);
            1: send(1, 1, 0, 1, 5'($urandom_range(0, 15)), 5'd0, addr, 32'h0);
            2: send(0, 0, 1, 0, 5'd0, 5'($urandom_range(0, 15)), addr, $urandom);
            default: send(0, 0, 0, 0, 5'd0, 5'd0, 32'h0, 32'h0);
         endcase
         tick();
         e = sb.pop_front();
         n_chk++; if (bus.RegWriteWB !== e.rw) begin n_fail++; $display("FAIL b2b_rw[%0d]: got %b want %b", i, bus.RegWriteWB, e.rw); end
         n_chk++; if (bus.MemToRegWB !== e.m2r) begin n_fail++; $display("FAIL b2b_m2r[%0d]: got %b want %b", i, bus.MemToRegWB, e.m2r); end
         n_chk++; if (bus.WriteRegisterWB !== e.wr) begin n_fail++; $display("FAIL b2b_wr[%0d]: got %0d want %0d", i, bus.WriteRegisterWB, e.wr); end
         n_chk++; if (bus.ALUResultWB !== e.alu) begin n_fail++; $display("FAIL b2b_alu[%0d]: got %h want %h", i, bus.ALUResultWB, e.alu); end
         n_chk++; if (bus.ReadDataWB !== e.rd) begin n_fail++; $display("FAIL b2b_rd[%0d]: got %h want %h", i, bus.ReadDataWB, e.rd); end
         n_chk++; if (bus.WriteDataWB !== e.wd) begin n_fail++; $display("FAIL b2b_wd[%0d]: got %h want %h", i, bus.WriteDataWB, e.wd); end
      end
   endtask

   initial begin
      rst = 1;
      bubble();
      model_reset();
      test_reset();
      test_store_load();
      test_wrap();
      test_forward();
      test_passthrough();
      test_read_write();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory stage of the five-stage MIPS pipeline, directly downstream of the EX/MEM register. Consumes the EX/MEM outputs, performs data-memory loads and stores against an internal word-addressed data memory, forwards write-back data into store data for load-then-store sequences, and registers the results into the MEM/WB pipeline register that drives register-file write-back.

## Interface
Parameters:
- ADDR_WIDTH, 10, word-index width; the memory holds 2^ADDR_WIDTH 32-bit words.

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- ALUResult  input  32  byte address for loads and stores, or the ALU result passed to write-back.
- ReadDataRF1  input  32  store data from the register file.
- WriteRegister  input  5  destination register.
- Rt  input  5  store-data source register.
- RegWrite, MemRead, MemWrite, MemToReg  input  1 each  control from EX/MEM.
- RegWriteWB  output  1  registered RegWrite.
- MemToRegWB  output  1  registered MemToReg.
- WriteRegisterWB  output  5  registered destination register.
- ALUResultWB  output  32  registered ALUResult.
- ReadDataWB  output  32  registered load data.
- WriteDataWB  output  32  combinational write-back value: MemToRegWB ? ReadDataWB : ALUResultWB.

## Operation
- Word index is ALUResult[ADDR_WIDTH+1:2]. Bits [1:0] are ignored, so unaligned addresses round down. Upper bits are ignored, so addresses wrap modulo 2^ADDR_WIDTH words.
- Memory read is combinational from the array. Memory write is synchronous on the rising edge when MemWrite=1 and rst=0.
- Store-data forwarding:
  - StoreData = WriteDataWB when RegWriteWB=1, WriteRegisterWB!=0, and WriteRegisterWB==Rt.
  - Otherwise StoreData = ReadDataRF1.
  - This covers a lw immediately followed by a sw of the loaded register.
- MEM/WB register, on each rising edge with rst=0:
  - RegWriteWB <= RegWrite.
  - MemToRegWB <= MemToReg.
  - WriteRegisterWB <= WriteRegister.
  - ALUResultWB <= ALUResult.
  - ReadDataWB <= MemRead ? mem[index] : 0.
- MemRead and MemWrite both at 1 (the decoder never issues this): the write occurs, and ReadDataWB captures the pre-write contents of the array.
- There is no stall or flush. A bubble arrives as all-zero control and produces RegWriteWB=0.

## Timing
- Reset (asynchronous, immediate): RegWriteWB=0, MemToRegWB=0, WriteRegisterWB=0, ALUResultWB=0, ReadDataWB=0, so WriteDataWB=0.
- The memory array is not cleared by reset. A write requested while rst=1 is suppressed.
- Latency: one cycle from EX/MEM outputs to MEM/WB outputs.
- Store at cycle N to address A, then load from A at cycle N+1: the load returns the stored value, because the write completes at the end of N.
- The forwarding path uses this block's own registered outputs. StoreData is valid within the same cycle that the store is in MEM.
- Rt=0 never forwards, even when WriteRegisterWB=0 and RegWriteWB=1.
- Reset deasserted mid-sequence: the first post-reset edge captures inputs normally.

## Test plan
- Reset: assert rst mid-cycle with nonzero inputs → all WB outputs read 0 immediately and remain 0 while rst=1; a MemWrite presented during reset leaves the target word unchanged.
- Store/load: sw 0xDEADBEEF at address 0x40, then lw from 0x40 next cycle → ReadDataWB=0xDEADBEEF and WriteDataWB=0xDEADBEEF with MemToRegWB=1, one cycle after the load.
- Address wrap/alignment (ADDR_WIDTH=10): store 0x11 at 0x1000, load from 0x0002 → ReadDataWB=0x11.
- Forwarding: lw $8 from an address holding 0x1234, immediately followed by sw $8 (Rt=8, ReadDataRF1=0xFFFF) to address 0x80 → mem[0x80]=0x1234. Repeat with Rt=9 → mem[0x80]=0xFFFF. Repeat with a $0 destination → no forwarding.
- Non-load pass-through: ALU op with ALUResult=0x55, MemRead=0, MemToReg=0, RegWrite=1, WriteRegister=3 → ALUResultWB=0x55, ReadDataWB=0, WriteDataWB=0x55, WriteRegisterWB=3.
- Simultaneous MemRead and MemWrite to an address holding 0xA: write 0xB → ReadDataWB=0xA, and a subsequent load returns 0xB.
